iomem_pwm_leds: RTL and testbench
=================================

# iomem_pwm_leds

Memory-mapped three-channel PWM LED controller on the picosoc `iomem` bus, next to the existing GPIO register. It decodes its own address window, holds control, prescaler, period and per-channel duty registers, and drives `pwm_out[2:0]` to the LED pins. A wrap-status flag can raise an interrupt toward a picosoc `irq_5..7` input.

## Interface
Parameters:
- `BASE_ADDR`, default 8'h04: value matched against `iomem_addr[31:24]`.

Ports (name, direction, width, meaning):
- `clk`  in  1: system clock (sysclk domain).
- `resetn`  in  1: reset, asynchronous, active-low.
- `iomem_valid`  in  1: bus request valid.
- `iomem_ready`  out  1: one-cycle completion pulse.
- `iomem_wstrb`  in  4: byte write strobes; all zero means read.
- `iomem_addr`  in  32: byte address.
- `iomem_wdata`  in  32: write data.
- `iomem_rdata`  out  32: read data, valid while `iomem_ready`=1.
- `pwm_out`  out  3: registered PWM outputs, one per LED.
- `irq`  out  1: level interrupt, `STATUS.WRAP & CTRL.IRQ_EN`.

## Operation
- Hit: `iomem_valid && !iomem_ready && iomem_addr[31:24]==BASE_ADDR`. Register offset is `iomem_addr[7:2]`; all other address bits are ignored.
- Register map (word offsets):
  - 0x00 CTRL: [2:0] channel enable, [3] RUN, [8] IRQ_EN.
  - 0x04 PRESCALE: [15:0].
  - 0x08 PERIOD: [7:0].
  - 0x0C, 0x10, 0x14 DUTY0..2: [7:0].
  - 0x18 COUNT: [7:0], read-only.
  - 0x1C STATUS: [0] WRAP; writing 1 clears it.
- Unimplemented bits and offsets read 0 and ignore writes.
- Writes honour `iomem_wstrb` per byte. Only the bytes covering each field are used.
- Time base:
  - Prescaler `pcnt` counts 0..PRESCALE. `tick` fires when `pcnt==PRESCALE`, and `pcnt` returns to 0.
  - On `tick`, `cnt` increments, or wraps to 0 when `cnt==PERIOD`. The wrap sets STATUS.WRAP.
  - With RUN=0, `pcnt` and `cnt` are held at 0 and no ticks occur.
  - Any write hit to PRESCALE or PERIOD clears `pcnt` and `cnt` on that same edge.
- Output: `pwm_out[i] <= CTRL[i] && (cnt < DUTY[i])`.
  - DUTY=0 gives constant low.
  - DUTY>PERIOD gives constant high.
- Simultaneous wrap and W1C of WRAP on the same edge: the set wins, so WRAP stays 1.
- Non-hit requests are ignored: no `ready`, no register change.

## Timing
- Reset values:
  - `iomem_ready`=0, `iomem_rdata`=0, `pwm_out`=0, `irq`=0.
  - CTRL=0, PRESCALE=0, PERIOD=8'hFF, DUTY0..2=0, `pcnt`=0, `cnt`=0, WRAP=0.
- Bus latency: `iomem_ready` is high exactly one cycle, on the edge after the first cycle of a hit.
  - It drops the following cycle even if `iomem_valid` is still high. A held request therefore produces one pulse every two cycles, matching the master's handshake.
- `iomem_rdata` returns the pre-write register value for a read-modify access on the same edge.
- The PWM period is (PRESCALE+1)·(PERIOD+1) clocks. With PRESCALE=0, `cnt` advances every clock.
- Timing relative to `cnt`:
  - `pwm_out` lags `cnt` by one clock.
  - `irq` rises one clock after the wrap edge, because it is derived from the registered WRAP flag.
- Async reset mid-transaction aborts the access. `iomem_ready` falls immediately and no write is committed.

## Structure
- Package `iomem_pwm_pkg` holds:
  - Offset localparams: `PWM_CTRL`, `PWM_PRESCALE`, `PWM_PERIOD`, `PWM_DUTY0..2`, `PWM_COUNT`, `PWM_STATUS`.
  - CTRL bit indices: `RUN_BIT`=3, `IRQ_EN_BIT`=8.
  - The reset value of PERIOD.
- Sub-module `pwm_timebase` contains the prescaler and period counter.
  - Inputs: `clk`, `resetn`, `run`, `clear`, `prescale`, `period`.
  - Outputs: `cnt`, `wrap_pulse`.
- The top level holds the bus decode, the register file and the comparators.

## Test plan
- Reset, then read all offsets. Expect CTRL=0, PERIOD=0xFF, DUTY*=0, STATUS=0, `pwm_out`=3'b000, and `ready` pulses exactly one cycle per access.
- PERIOD=9, PRESCALE=0, DUTY0=3, CTRL=0x9. Expect `pwm_out[0]` high 3 of every 10 clocks. Set DUTY0=0 for constant 0, then DUTY0=12 for constant 1.
- PRESCALE=4, PERIOD=1, CTRL=0x108. Expect WRAP set and `irq`=1 after 10 clocks. Write STATUS=1 and `irq` drops. A clear issued on the exact wrap edge leaves WRAP=1.
- Write `wdata`=0xAABBCCDD to PRESCALE with `wstrb`=4'b0010. Expect a readback of 0x0000CC00 and `cnt` forced to 0.
- Access an address with `[31:24]`=8'h03: no `ready` and no change. Assert `resetn` low mid-access: `ready`=0 and all registers return to reset values.

Source files
------------

// File: rtl/iomem_pwm_pkg.sv
// Shared register map, field positions and CTRL payload layout for the iomem PWM LED block.
package iomem_pwm_pkg;

   localparam int unsigned OFF_W  = 6;
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned PRE_W  = 16;
   localparam int unsigned NUM_CH = 3;

   // Word offsets taken from iomem_addr[7:2]
   localparam logic [OFF_W-1:0] PWM_CTRL     = 6'd0;
   localparam logic [OFF_W-1:0] PWM_PRESCALE = 6'd1;
   localparam logic [OFF_W-1:0] PWM_PERIOD   = 6'd2;
   localparam logic [OFF_W-1:0] PWM_DUTY0    = 6'd3;
   localparam logic [OFF_W-1:0] PWM_DUTY1    = 6'd4;
   localparam logic [OFF_W-1:0] PWM_DUTY2    = 6'd5;
   localparam logic [OFF_W-1:0] PWM_COUNT    = 6'd6;
   localparam logic [OFF_W-1:0] PWM_STATUS   = 6'd7;

   localparam int unsigned RUN_BIT    = 3;
   localparam int unsigned IRQ_EN_BIT = 8;

   localparam logic [CNT_W-1:0] PERIOD_RST = 8'hFF;

   typedef struct packed {
      logic              irq_en;
      logic              run;
      logic [NUM_CH-1:0] en;
   } ctrl_t;

   function automatic logic [31:0] ctrl_to_word(input ctrl_t c);
      logic [31:0] w;
      w                = '0;
      w[NUM_CH-1:0]    = c.en;
      w[RUN_BIT]       = c.run;
      w[IRQ_EN_BIT]    = c.irq_en;
      return w;
   endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler plus period counter; wrap_pulse marks the edge on which cnt returns to 0.
module pwm_timebase
   import iomem_pwm_pkg::*;
(
   input  logic             clk,
   input  logic             resetn,
   input  logic             run,
   input  logic             clear,
   input  logic [PRE_W-1:0] prescale,
   input  logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] cnt,
   output logic             wrap_pulse
);

   logic [PRE_W-1:0] pcnt_q, pcnt_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick;

   always_comb begin
      tick       = run && (pcnt_q == prescale);
      pcnt_d     = pcnt_q + PRE_W'(1);
      cnt_d      = cnt_q;
      wrap_pulse = 1'b0;
      if (tick) begin
         pcnt_d = '0;
         if (cnt_q == period) begin
            cnt_d      = '0;
            wrap_pulse = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
      // A stopped or just-reprogrammed time base restarts from zero without flagging a wrap
      if (clear || !run) begin
         pcnt_d     = '0;
         cnt_d      = '0;
         wrap_pulse = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pcnt_q <= '0;
         cnt_q  <= '0;
      end else begin
         pcnt_q <= pcnt_d;
         cnt_q  <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/iomem_pwm_leds.sv
// Three-channel PWM LED controller on the picosoc iomem bus: decode, register file, comparators, irq.
module iomem_pwm_leds
   import iomem_pwm_pkg::*;
#(
   parameter logic [7:0] BASE_ADDR = 8'h04
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        iomem_valid,
   output logic        iomem_ready,
   input  logic [3:0]  iomem_wstrb,
   input  logic [31:0] iomem_addr,
   input  logic [31:0] iomem_wdata,
   output logic [31:0] iomem_rdata,
   output logic [2:0]  pwm_out,
   output logic        irq
);

   ctrl_t                         ctrl_q, ctrl_d;
   logic [PRE_W-1:0]              prescale_q, prescale_d;
   logic [CNT_W-1:0]              period_q, period_d;
   logic [NUM_CH-1:0][CNT_W-1:0]  duty_q, duty_d;
   logic                          wrap_q, wrap_d;
   logic                          ready_q, ready_d;
   logic [31:0]                   rdata_q, rdata_d;
   logic [NUM_CH-1:0]             pwm_q, pwm_d;
   logic                          irq_q, irq_d;

   logic             hit, wr, clear;
   logic [OFF_W-1:0] off;
   logic [31:0]      rd_word;
   logic [CNT_W-1:0] cnt;
   logic             wrap_pulse;
   logic             unused_bits;

   assign unused_bits = ^{iomem_addr[23:8], iomem_addr[1:0], iomem_wdata[31:16], iomem_wstrb[3:2]};

   // Decode; a hit is never taken in the ready cycle so a held request pulses every other clock
   always_comb begin
      hit   = iomem_valid && !ready_q && (iomem_addr[31:24] == BASE_ADDR);
      wr    = hit && (iomem_wstrb != 4'b0000);
      off   = iomem_addr[7:2];
      clear = wr && ((off == PWM_PRESCALE) || (off == PWM_PERIOD));
   end

   always_comb begin
      rd_word = '0;
      case (off)
         PWM_CTRL:     rd_word = ctrl_to_word(ctrl_q);
         PWM_PRESCALE: rd_word = 32'(prescale_q);
         PWM_PERIOD:   rd_word = 32'(period_q);
         PWM_DUTY0:    rd_word = 32'(duty_q[0]);
         PWM_DUTY1:    rd_word = 32'(duty_q[1]);
         PWM_DUTY2:    rd_word = 32'(duty_q[2]);
         PWM_COUNT:    rd_word = 32'(cnt);
         PWM_STATUS:   rd_word = 32'(wrap_q);
         default:      rd_word = '0;
      endcase
   end

   always_comb begin
      ctrl_d     = ctrl_q;
      prescale_d = prescale_q;
      period_d   = period_q;
      duty_d     = duty_q;
      wrap_d     = wrap_q;
      ready_d    = hit;
      rdata_d    = hit ? rd_word : '0;
      if (wr) begin
         case (off)
            PWM_CTRL: begin
               if (iomem_wstrb[0]) begin
                  ctrl_d.en  = iomem_wdata[NUM_CH-1:0];
                  ctrl_d.run = iomem_wdata[RUN_BIT];
               end
               if (iomem_wstrb[1]) ctrl_d.irq_en = iomem_wdata[IRQ_EN_BIT];
            end
            PWM_PRESCALE: begin
               if (iomem_wstrb[0]) prescale_d[7:0]  = iomem_wdata[7:0];
               if (iomem_wstrb[1]) prescale_d[15:8] = iomem_wdata[15:8];
            end
            PWM_PERIOD: if (iomem_wstrb[0]) period_d  = iomem_wdata[7:0];
            PWM_DUTY0:  if (iomem_wstrb[0]) duty_d[0] = iomem_wdata[7:0];
            PWM_DUTY1:  if (iomem_wstrb[0]) duty_d[1] = iomem_wdata[7:0];
            PWM_DUTY2:  if (iomem_wstrb[0]) duty_d[2] = iomem_wdata[7:0];
            PWM_STATUS: if (iomem_wstrb[0] && iomem_wdata[0]) wrap_d = 1'b0;
            default: ;
         endcase
      end
      // A wrap on the same edge as a W1C keeps the flag set
      if (wrap_pulse) wrap_d = 1'b1;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         pwm_d[i] = ctrl_q.en[i] && (cnt < duty_q[i]);
      end
      irq_d = wrap_q && ctrl_q.irq_en;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ctrl_q     <= '0;
         prescale_q <= '0;
         period_q   <= PERIOD_RST;
         duty_q     <= '0;
         wrap_q     <= 1'b0;
         ready_q    <= 1'b0;
         rdata_q    <= '0;
         pwm_q      <= '0;
         irq_q      <= 1'b0;
      end else begin
         ctrl_q     <= ctrl_d;
         prescale_q <= prescale_d;
         period_q   <= period_d;
         duty_q     <= duty_d;
         wrap_q     <= wrap_d;
         ready_q    <= ready_d;
         rdata_q    <= rdata_d;
         pwm_q      <= pwm_d;
         irq_q      <= irq_d;
      end
   end

   pwm_timebase u_timebase (
      .clk        (clk),
      .resetn     (resetn),
      .run        (ctrl_q.run),
      .clear      (clear),
      .prescale   (prescale_q),
      .period     (period_q),
      .cnt        (cnt),
      .wrap_pulse (wrap_pulse)
   );

   assign iomem_ready = ready_q;
   assign iomem_rdata = rdata_q;
   assign pwm_out     = pwm_q;
   assign irq         = irq_q;

endmodule

// File: tb/tb_iomem_pwm_leds.sv
// Scoreboard bench for iomem_pwm_leds: bus reads checked against queued expectations, PWM/irq timing checked per scenario.
module tb_iomem_pwm_leds;

   logic        clk = 1'b0;
   logic        resetn;
   logic        iomem_valid;
   logic        iomem_ready;
   logic [3:0]  iomem_wstrb;
   logic [31:0] iomem_addr;
   logic [31:0] iomem_wdata;
   logic [31:0] iomem_rdata;
   logic [2:0]  pwm_out;
   logic        irq;

   int checks   = 0;
   int failures = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   iomem_pwm_leds #(.BASE_ADDR(8'h04)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .iomem_valid (iomem_valid),
      .iomem_ready (iomem_ready),
      .iomem_wstrb (iomem_wstrb),
      .iomem_addr  (iomem_addr),
      .iomem_wdata (iomem_wdata),
      .iomem_rdata (iomem_rdata),
      .pwm_out     (pwm_out),
      .irq         (irq)
   );

   function automatic logic [31:0] a_of(input logic [5:0] off);
      return {8'h04, 16'h0000, off, 2'b00};
   endfunction

   // Drives one request, waits (bounded) for ready, then reports whether ready dropped the next cycle
   task automatic bus_xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int max_cyc, output logic [31:0] rd, output bit ok, output bit dropped);
      @(negedge clk);
      iomem_valid = 1'b1;
      iomem_addr  = a;
      iomem_wdata = d;
      iomem_wstrb = s;
      ok          = 1'b0;
      rd          = '0;
      for (int i = 0; i < max_cyc; i++) begin
         @(posedge clk); #1;
         if (iomem_ready) begin
            ok = 1'b1;
            rd = iomem_rdata;
            break;
         end
      end
      iomem_valid = 1'b0;
      iomem_wstrb = 4'b0000;
      @(posedge clk); #1;
      dropped = !iomem_ready;
   endtask

   task automatic wr(input logic [5:0] off, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] rd;
      bit ok, dropped;
      bus_xfer(a_of(off), d, s, 10, rd, ok, dropped);
   endtask

   task automatic test_reset();
      logic [31:0] rst_exp [0:9];
      logic [31:0] rd, exp;
      bit ok, dropped;
      rst_exp = '{32'h0, 32'h0, 32'hFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
      checks++;
      if (iomem_ready !== 1'b0 || iomem_rdata !== 32'h0) begin
         failures++;
         $display("FAIL reset_bus ready=%b rdata=%h exp ready=0 rdata=0", iomem_ready, iomem_rdata);
      end
      checks++;
      if (pwm_out !== 3'b000 || irq !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs pwm=%b irq=%b exp pwm=000 irq=0", pwm_out, irq);
      end
      for (int i = 0; i < 10; i++) begin
         logic [5:0] off;
         off = (i < 8) ? 6'(i) : ((i == 8) ? 6'd8 : 6'd63);
         exp_q.push_back(rst_exp[i]);
         bus_xfer(a_of(off), 32'h0, 4'b0000, 10, rd, ok, dropped);
         exp = exp_q.pop_front();
         checks++;
         if (!ok || rd !== exp) begin
            failures++;
            $display("FAIL reset_read off=%0d ok=%b got=%h exp=%h", off, ok, rd, exp);
         end
         checks++;
         if (!dropped) begin
            failures++;
            $display("FAIL ready_pulse_width off=%0d ready still high, exp single-cycle pulse", off);
         end
      end
   endtask

   task automatic test_pwm_duty();
      logic [7:0] duty_vals [0:4];
      int         exp_hi [0:4];
      int         hi, other, hi1;
      duty_vals = '{8'd3, 8'd0, 8'd12, 8'd9, 8'd10};
      exp_hi    = '{9, 0, 30, 27, 30};
      wr(6'd2, 32'd9, 4'hF);
      wr(6'd1, 32'd0, 4'hF);
      wr(6'd4, 32'd5, 4'hF);
      wr(6'd0, 32'h9, 4'hF);
      for (int k = 0; k < 5; k++) begin
         wr(6'd3, 32'(duty_vals[k]), 4'hF);
         hi = 0; other = 0;
         for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            hi    += int'(pwm_out[0]);
            other += int'(pwm_out[2:1] != 2'b00);
         end
         checks++;
         if (hi != exp_hi[k]) begin
            failures++;
            $display("FAIL pwm0_duty duty=%0d high=%0d/30 exp=%0d", duty_vals[k], hi, exp_hi[k]);
         end
         checks++;
         if (other != 0) begin
            failures++;
            $display("FAIL pwm_disabled_ch duty=%0d active=%0d exp=0", duty_vals[k], other);
         end
      end
      wr(6'd0, 32'hB, 4'hF);
      hi1 = 0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk); #1;
         hi1 += int'(pwm_out[1]);
      end
      checks++;
      if (hi1 != 15) begin
         failures++;
         $display("FAIL pwm1_duty5 high=%0d/30 exp=15", hi1);
      end
   endtask

   task automatic test_wrap_irq();
      logic [31:0] rd, exp;
      bit ok, dropped;
      int n;
      wr(6'd0, 32'h0, 4'hF);
      wr(6'd7, 32'h1, 4'hF);
      wr(6'd1, 32'd4, 4'hF);
      wr(6'd2, 32'd1, 4'hF);
      exp_q.push_back(32'h0);
      bus_xfer(a_of(6'd7), 32'h0, 4'b0000, 10, rd, ok, dropped);
      exp = exp_q.pop_front();
      checks++;
      if (!ok || rd !== exp || irq !== 1'b0) begin
         failures++;
         $display("FAIL status_cleared ok=%b got=%h irq=%b exp=%h irq=0", ok, rd, irq, exp);
      end
      wr(6'd0, 32'h108, 4'hF);
      n = 0;
      for (int c = 1; c <= 30; c++) begin
         @(posedge clk); #1;
         if (irq) begin n = c; break; end
      end
      checks++;
      if (n != 10) begin
         failures++;
         $display("FAIL irq_rise_latency got=%0d clocks exp=10 (0=never)", n);
      end
      wr(6'd7, 32'h1, 4'h1);
      checks++;
      if (irq !== 1'b0) begin
         failures++;
         $display("FAIL irq_after_w1c irq=%b exp=0", irq);
      end
      exp_q.push_back(32'h0);
      bus_xfer(a_of(6'd7), 32'h0, 4'b0000, 10, rd, ok, dropped);
      exp = exp_q.pop_front();
      checks++;
      if (!ok || rd !== exp) begin
         failures++;
         $display("FAIL status_after_w1c ok=%b got=%h exp=%h", ok, rd, exp);
      end
      n = 0;
      for (int c = 1; c <= 30; c++) begin
         @(posedge clk); #1;
         if (irq) begin n = c; break; end
      end
      checks++;
      if (n == 0) begin
         failures++;
         $display("FAIL irq_second_wrap irq never rose within 30 clocks");
      end
      // Next wrap is 9 edges after this point; issue the W1C so it lands on that edge
      repeat (8) @(posedge clk);
      #1;
      wr(6'd7, 32'h1, 4'h1);
      exp_q.push_back(32'h1);
      bus_xfer(a_of(6'd7), 32'h0, 4'b0000, 10, rd, ok, dropped);
      exp = exp_q.pop_front();
      checks++;
      if (!ok || rd !== exp || irq !== 1'b1) begin
         failures++;
         $display("FAIL wrap_set_wins ok=%b status=%h irq=%b exp status=%h irq=1", ok, rd, irq, exp);
      end
      wr(6'd0, 32'h0, 4'hF);
   endtask

   task automatic test_wstrb();
      logic [31:0] rd, exp;
      bit ok, dropped;
      logic [5:0]  offs [0:3];
      logic [31:0] exps [0:3];
      wr(6'd1, 32'h0, 4'hF);
      wr(6'd2, 32'hFF, 4'hF);
      wr(6'd0, 32'h8, 4'hF);
      repeat (20) @(posedge clk);
      wr(6'd1, 32'hAABBCCDD, 4'b0010);
      wr(6'd8, 32'hFFFFFFFF, 4'hF);
      wr(6'd3, 32'h1234, 4'b0010);
      offs = '{6'd1, 6'd6, 6'd8, 6'd3};
      exps = '{32'h0000CC00, 32'h0, 32'h0, 32'd10};
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(exps[i]);
         bus_xfer(a_of(offs[i]), 32'h0, 4'b0000, 10, rd, ok, dropped);
         exp = exp_q.pop_front();
         checks++;
         if (!ok || rd !== exp) begin
            failures++;
            $display("FAIL wstrb_read off=%0d ok=%b got=%h exp=%h", offs[i], ok, rd, exp);
         end
      end
      wr(6'd0, 32'hFFFFFFFF, 4'hF);
      wr(6'd0, 32'h0, 4'b0001);
      exp_q.push_back(32'h100);
      bus_xfer(a_of(6'd0), 32'h0, 4'b0000, 10, rd, ok, dropped);
      exp = exp_q.pop_front();
      checks++;
      if (!ok || rd !== exp) begin
         failures++;
         $display("FAIL ctrl_byte_lanes ok=%b got=%h exp=%h", ok, rd, exp);
      end
   endtask

   task automatic test_nonhit();
      logic [31:0] rd, exp;
      bit ok, dropped;
      bus_xfer(32'h03000008, 32'h12, 4'hF, 8, rd, ok, dropped);
      checks++;
      if (ok) begin
         failures++;
         $display("FAIL nonhit_ready ready=1 exp no ready");
      end
      exp_q.push_back(32'hFF);
      bus_xfer(32'h04FFFF0B, 32'h0, 4'b0000, 10, rd, ok, dropped);
      exp = exp_q.pop_front();
      checks++;
      if (!ok || rd !== exp) begin
         failures++;
         $display("FAIL nonhit_no_change ok=%b period=%h exp=%h", ok, rd, exp);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp;
      @(negedge clk);
      iomem_valid = 1'b1;
      iomem_addr  = a_of(6'd2);
      iomem_wstrb = 4'b0000;
      for (int k = 0; k < 3; k++) exp_q.push_back(32'hFF);
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         checks++;
         if (iomem_ready !== ((k % 2) == 0)) begin
            failures++;
            $display("FAIL held_valid_ready cycle=%0d ready=%b exp=%b", k, iomem_ready, (k % 2) == 0);
         end
         if (iomem_ready && exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            checks++;
            if (iomem_rdata !== exp) begin
               failures++;
               $display("FAIL held_valid_rdata cycle=%0d got=%h exp=%h", k, iomem_rdata, exp);
            end
         end
      end
      iomem_valid = 1'b0;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL held_valid_pulses missing=%0d exp=0", exp_q.size());
         exp_q.delete();
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd, exp;
      bit ok, dropped;
      logic [5:0]  offs [0:4];
      logic [31:0] exps [0:4];
      wr(6'd4, 32'h7, 4'hF);
      wr(6'd0, 32'h10F, 4'hF);
      @(negedge clk);
      iomem_valid = 1'b1;
      iomem_addr  = a_of(6'd4);
      iomem_wdata = 32'h55;
      iomem_wstrb = 4'hF;
      @(posedge clk); #1;
      checks++;
      if (iomem_ready !== 1'b1) begin
         failures++;
         $display("FAIL mid_access_ready ready=%b exp=1", iomem_ready);
      end
      #1 resetn = 1'b0;
      #1;
      checks++;
      if (iomem_ready !== 1'b0 || pwm_out !== 3'b000 || irq !== 1'b0 || iomem_rdata !== 32'h0) begin
         failures++;
         $display("FAIL async_reset_outputs ready=%b pwm=%b irq=%b rdata=%h exp all 0",
                  iomem_ready, pwm_out, irq, iomem_rdata);
      end
      iomem_valid = 1'b0;
      iomem_wstrb = 4'b0000;
      repeat (2) @(posedge clk);
      @(negedge clk) resetn = 1'b1;
      offs = '{6'd4, 6'd0, 6'd2, 6'd1, 6'd7};
      exps = '{32'h0, 32'h0, 32'hFF, 32'h0, 32'h0};
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(exps[i]);
         bus_xfer(a_of(offs[i]), 32'h0, 4'b0000, 10, rd, ok, dropped);
         exp = exp_q.pop_front();
         checks++;
         if (!ok || rd !== exp) begin
            failures++;
            $display("FAIL post_reset_read off=%0d ok=%b got=%h exp=%h", offs[i], ok, rd, exp);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn      = 1'b0;
      iomem_valid = 1'b0;
      iomem_wstrb = 4'b0000;
      iomem_addr  = '0;
      iomem_wdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk) resetn = 1'b1;
      test_reset();
      test_pwm_duty();
      test_wrap_irq();
      test_wstrb();
      test_nonhit();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
